// File: rtl/idex_pkg.sv
// Shared field layout for the ID/EX pipeline register: control bit positions,
// data-bundle offsets and small packing helpers.
package idex_pkg;

  localparam int unsigned DATA_W_DEF   = 122;
  localparam int unsigned CTRL_W_DEF   = 12;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned IMM_W        = 16;
  localparam int unsigned REG_IDX_W    = 5;

  // Control bundle bit positions
  localparam int unsigned CTRL_REGWRITE  = 11;
  localparam int unsigned CTRL_MEMTOREG  = 10;
  localparam int unsigned CTRL_BRANCH    = 9;
  localparam int unsigned CTRL_MEMREAD   = 8;
  localparam int unsigned CTRL_MEMWRITE  = 7;
  localparam int unsigned CTRL_REGDST    = 6;
  localparam int unsigned CTRL_ALUSRC    = 5;
  localparam int unsigned CTRL_ALUOP_LSB = 0;
  localparam int unsigned CTRL_ALUOP_W   = 5;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  // Data bundle field offsets (lsb of each field)
  localparam int unsigned DATA_RD_LSB     = 0;
  localparam int unsigned DATA_RT_LSB     = 5;
  localparam int unsigned DATA_IMM_LSB    = 10;
  localparam int unsigned DATA_RTDATA_LSB = 26;
  localparam int unsigned DATA_RSDATA_LSB = 58;
  localparam int unsigned DATA_PC4_LSB    = 90;

  typedef struct packed {
    logic [WORD_W-1:0]    pc4;
    logic [WORD_W-1:0]    rs_data;
    logic [WORD_W-1:0]    rt_data;
    logic [IMM_W-1:0]     imm;
    logic [REG_IDX_W-1:0] rt;
    logic [REG_IDX_W-1:0] rd;
  } idex_data_t;

  typedef struct packed {
    logic                    regwrite;
    logic                    memtoreg;
    logic                    branch;
    logic                    memread;
    logic                    memwrite;
    logic                    regdst;
    logic                    alusrc;
    logic [CTRL_ALUOP_W-1:0] aluop;
  } idex_ctrl_t;

  function automatic logic [DATA_W_DEF-1:0] make_data(
    input logic [WORD_W-1:0]    pc4,
    input logic [WORD_W-1:0]    rs_data,
    input logic [WORD_W-1:0]    rt_data,
    input logic [IMM_W-1:0]     imm,
    input logic [REG_IDX_W-1:0] rt,
    input logic [REG_IDX_W-1:0] rd
  );
    logic [DATA_W_DEF-1:0] d;
    d = '0;
    d[DATA_PC4_LSB    +: WORD_W]    = pc4;
    d[DATA_RSDATA_LSB +: WORD_W]    = rs_data;
    d[DATA_RTDATA_LSB +: WORD_W]    = rt_data;
    d[DATA_IMM_LSB    +: IMM_W]     = imm;
    d[DATA_RT_LSB     +: REG_IDX_W] = rt;
    d[DATA_RD_LSB     +: REG_IDX_W] = rd;
    return d;
  endfunction

  function automatic logic [CTRL_W_DEF-1:0] make_ctrl(
    input logic                    regwrite,
    input logic                    memtoreg,
    input logic                    branch,
    input logic                    memread,
    input logic                    memwrite,
    input logic                    regdst,
    input logic                    alusrc,
    input logic [CTRL_ALUOP_W-1:0] aluop
  );
    logic [CTRL_W_DEF-1:0] c;
    c = CTRL_NOP;
    c[CTRL_REGWRITE] = regwrite;
    c[CTRL_MEMTOREG] = memtoreg;
    c[CTRL_BRANCH]   = branch;
    c[CTRL_MEMREAD]  = memread;
    c[CTRL_MEMWRITE] = memwrite;
    c[CTRL_REGDST]   = regdst;
    c[CTRL_ALUSRC]   = alusrc;
    c[CTRL_ALUOP_LSB +: CTRL_ALUOP_W] = aluop;
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One elastic pipeline stage: main register plus skid register, with a
// registered ready so out_ready never reaches in_ready combinationally.
module pipe_skid_stage #(
  parameter int unsigned W = 134
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         push;
  logic         pop;

  // Next-state: flush wins; otherwise pop refills main from skid or input
  always_comb begin
    push         = in_valid && !skid_valid_q;
    pop          = main_valid_q && out_ready;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_data_d  = in_payload;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = in_payload;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_payload;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready    = !skid_valid_q;
  assign out_valid   = main_valid_q;
  assign out_payload = main_data_q;

endmodule

// File: rtl/idex_elastic_pipe.sv
// ID/EX pipeline register built from chained elastic stages, with bubble
// masking of the control bundle and a saturating stall-cycle counter.
module idex_elastic_pipe
  import idex_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned CTRL_W     = CTRL_W_DEF,
  parameter int unsigned NUM_STAGES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PAYLOAD_W = DATA_W + CTRL_W;
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  if (NUM_STAGES < 1 || NUM_STAGES > 4) begin : g_bad_num_stages
    $error("idex_elastic_pipe: NUM_STAGES must be in 1..4");
  end

  logic [NUM_STAGES:0]                stg_valid;
  logic [NUM_STAGES:0]                stg_ready;
  logic [NUM_STAGES:0][PAYLOAD_W-1:0] stg_payload;
  logic [CNT_W-1:0]                   stall_cnt_q, stall_cnt_d;

  assign stg_valid[0]          = in_valid;
  assign stg_payload[0]        = {in_data, in_ctrl};
  assign in_ready              = stg_ready[0];
  assign stg_ready[NUM_STAGES] = out_ready;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    pipe_skid_stage #(
      .W (PAYLOAD_W)
    ) u_stage (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .flush       (flush),
      .in_valid    (stg_valid[i]),
      .in_ready    (stg_ready[i]),
      .in_payload  (stg_payload[i]),
      .out_valid   (stg_valid[i+1]),
      .out_ready   (stg_ready[i+1]),
      .out_payload (stg_payload[i+1])
    );
  end

  // A bubble presents a NOP so RegWrite/MemWrite can never leak into EX
  assign out_valid = stg_valid[NUM_STAGES];
  assign out_data  = stg_payload[NUM_STAGES][PAYLOAD_W-1 -: DATA_W];
  assign out_ctrl  = out_valid ? stg_payload[NUM_STAGES][CTRL_W-1:0] : CTRL_W'(CTRL_NOP);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_idex_elastic_pipe.sv
// Self-checking bench for idex_elastic_pipe (2 stages, 4-bit stall counter):
// directed scenarios plus random traffic against a FIFO scoreboard.
module tb_idex_elastic_pipe;
  import idex_pkg::*;

  localparam int unsigned DW        = 122;
  localparam int unsigned CW        = 12;
  localparam int unsigned NS        = 2;
  localparam int unsigned CNTW      = 4;
  localparam int unsigned STALL_MAX = (1 << CNTW) - 1;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic [CW-1:0]   in_ctrl = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic [CNTW-1:0] stall_cnt;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  entry_t      model_q[$];
  int unsigned exp_stall = 0;
  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  int unsigned nxt = 0;

  idex_elastic_pipe #(
    .DATA_W     (DW),
    .CTRL_W     (CW),
    .NUM_STAGES (NS),
    .CNT_W      (CNTW)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard step: settle accept/pop/flush at the coming edge, then check.
  task automatic tick();
    entry_t e;
    logic   acc;
    logic   pop;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop) begin
      if (model_q.size() == 0) begin
        chk("pop_unexpected", 128'(out_valid), 128'(1'b0));
      end else begin
        e = model_q.pop_front();
        chk("pop_data", 128'(out_data), 128'(e.d));
        chk("pop_ctrl", 128'(out_ctrl), 128'(e.c));
      end
    end
    if (out_valid && !out_ready && exp_stall != STALL_MAX) exp_stall++;
    if (flush) begin
      model_q.delete();
    end else if (acc) begin
      e.d = in_data;
      e.c = in_ctrl;
      model_q.push_back(e);
    end
    @(posedge Clk);
    #1;
    chk("stall_cnt", 128'(stall_cnt), 128'(exp_stall));
    if (!out_valid) chk("bubble_ctrl", 128'(out_ctrl), 128'd0);
    if (model_q.size() == 0) chk("empty_valid", 128'(out_valid), 128'(1'b0));
  endtask

  task automatic stream_tick();
    logic acc;
    in_valid = 1'b1;
    in_data  = DW'(nxt);
    in_ctrl  = CW'(32'h800 | (nxt & 32'h7ff));
    acc      = in_ready;
    tick();
    if (acc) nxt++;
  endtask

  task automatic apply_reset(input int unsigned cycles);
    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    model_q.delete();
    exp_stall = 0;
  endtask

  task automatic drain(input int unsigned cycles);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (cycles) tick();
    chk("drain_pending", 128'(model_q.size()), 128'd0);
    chk("drain_valid", 128'(out_valid), 128'(1'b0));
  endtask

  initial begin
    logic exp_v;

    // Reset / idle
    apply_reset(3);
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("rst_out_data", 128'(out_data), 128'd0);
    chk("rst_stall_cnt", 128'(stall_cnt), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    tick();
    chk("idle_in_ready", 128'(in_ready), 128'(1'b1));

    // Streaming with no backpressure: entry c accepted at edge c, visible after edge c+1
    out_ready = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      in_valid = (c <= 8);
      in_data  = DW'(c);
      in_ctrl  = CW'(32'h800 | c);
      chk("stream_in_ready", 128'(in_ready), 128'(1'b1));
      tick();
      exp_v = (c >= 2 && c <= 9);
      chk("stream_valid", 128'(out_valid), 128'(exp_v));
      if (exp_v) begin
        chk("stream_data", 128'(out_data), 128'(c - 1));
        chk("stream_ctrl", 128'(out_ctrl), 128'(32'h800 | (c - 1)));
        chk("stream_regwrite", 128'(out_ctrl[CTRL_REGWRITE]), 128'(1'b1));
      end
    end

    // Backpressure: 5 stalled edges with a full pipe
    nxt = 100;
    out_ready = 1'b1;
    repeat (3) stream_tick();
    chk("bp_pre_valid", 128'(out_valid), 128'(1'b1));
    out_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      stream_tick();
      chk("bp_in_ready", 128'(in_ready), 128'((b == 1) ? 1'b1 : 1'b0));
    end
    chk("bp_stall_cnt", 128'(stall_cnt), 128'd5);
    out_ready = 1'b1;
    repeat (6) stream_tick();
    drain(8);

    // Flush with three entries in flight and an input on the flush cycle
    out_ready = 1'b0;
    repeat (3) stream_tick();
    chk("fl_inflight", 128'(model_q.size()), 128'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'(128'hDEAD_BEEF_0BAD_F00D);
    in_ctrl  = CW'(12'hFFF);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 128'(out_valid), 128'(1'b0));
    chk("fl_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("fl_in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      tick();
      chk("fl_no_ghost", 128'(out_valid), 128'(1'b0));
    end

    // Saturation of the 4-bit stall counter
    apply_reset(2);
    nxt = 200;
    stream_tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (22) tick();
    chk("sat_stall_cnt", 128'(stall_cnt), 128'(STALL_MAX));
    chk("sat_out_valid", 128'(out_valid), 128'(1'b1));
    drain(4);
    chk("sat_held", 128'(stall_cnt), 128'(STALL_MAX));

    // Asynchronous reset mid-stream with skids full
    apply_reset(2);
    nxt = 300;
    out_ready = 1'b0;
    repeat (4) stream_tick();
    chk("ar_in_ready_low", 128'(in_ready), 128'(1'b0));
    in_valid = 1'b0;
    #3;
    Reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 128'(out_valid), 128'(1'b0));
    chk("ar_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("ar_stall_cnt", 128'(stall_cnt), 128'd0);
    chk("ar_in_ready", 128'(in_ready), 128'(1'b1));
    model_q.delete();
    exp_stall = 0;
    @(posedge Clk);
    #1;
    Reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (10) stream_tick();
    drain(6);

    // Random traffic with occasional flushes
    for (int r = 0; r < 400; r++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = make_data($urandom, $urandom, $urandom, 16'($urandom),
                            5'($urandom), 5'($urandom));
      in_ctrl   = make_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                            1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      tick();
    end
    drain(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
